// File: rtl/udp_tx_ctrl_pkg.sv
// Shared types and default timing for the UDP transmit initiator and its ARP resolver.
package udp_tx_ctrl_pkg;

  localparam int DEF_ARP_TIMEOUT = 125_000_000;
  localparam int DEF_ARP_RETRIES = 3;
  localparam int DEF_IFG_CYCLES  = 12;
  localparam int DEF_TMO_W       = 27;

  typedef enum logic [2:0] {
    IDLE,
    ARP_REQ,
    ARP_WAIT,
    TX_REQ,
    WRITE,
    WAIT_END,
    GAP
  } tx_state_t;

  typedef enum logic {
    RES_IDLE,
    RES_WAIT
  } res_state_t;

  // Counter width able to hold values 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/udp_tx_arp_resolver.sv
// Issues ARP requests with per-request timeout and bounded retries; reports a
// one-cycle resolved or failed pulse.
module udp_tx_arp_resolver
  import udp_tx_ctrl_pkg::*;
#(
  parameter int ARP_TIMEOUT = DEF_ARP_TIMEOUT,
  parameter int ARP_RETRIES = DEF_ARP_RETRIES,
  parameter int TMO_W       = DEF_TMO_W
) (
  input  logic gmii_tx_clk,
  input  logic rst_n,
  input  logic start,
  input  logic arp_found,
  output logic arp_request_req,
  output logic resolved,
  output logic failed
);

  localparam int TRY_W = cnt_width(ARP_RETRIES + 1);

  res_state_t       state_reg;
  logic [TMO_W-1:0] tmo_reg;
  logic [TRY_W-1:0] tries_reg;

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= RES_IDLE;
      tmo_reg         <= '0;
      tries_reg       <= '0;
      arp_request_req <= 1'b0;
      resolved        <= 1'b0;
      failed          <= 1'b0;
    end else begin
      arp_request_req <= 1'b0;
      resolved        <= 1'b0;
      failed          <= 1'b0;
      case (state_reg)
        RES_IDLE: begin
          if (start) begin
            arp_request_req <= 1'b1;
            tries_reg       <= TRY_W'(1);
            tmo_reg         <= '0;
            state_reg       <= RES_WAIT;
          end
        end
        RES_WAIT: begin
          // A reply arriving on the timeout cycle still counts as resolved.
          if (arp_found) begin
            resolved  <= 1'b1;
            state_reg <= RES_IDLE;
          end else if (tmo_reg == TMO_W'(ARP_TIMEOUT - 1)) begin
            if (tries_reg < TRY_W'(ARP_RETRIES)) begin
              arp_request_req <= 1'b1;
              tries_reg       <= tries_reg + 1'b1;
              tmo_reg         <= '0;
            end else begin
              failed    <= 1'b1;
              state_reg <= RES_IDLE;
            end
          end else begin
            tmo_reg <= tmo_reg + 1'b1;
          end
        end
        default: state_reg <= RES_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/udp_tx_ctrl.sv
// User-side UDP transmit initiator: resolves the destination MAC, raises udp_tx_req
// and streams a fixed-length payload from a valid/ready source into the stack TX RAM.
module udp_tx_ctrl
  import udp_tx_ctrl_pkg::*;
#(
  parameter int ARP_TIMEOUT = DEF_ARP_TIMEOUT,
  parameter int ARP_RETRIES = DEF_ARP_RETRIES,
  parameter int IFG_CYCLES  = DEF_IFG_CYCLES,
  parameter int TMO_W       = DEF_TMO_W
) (
  input  logic        gmii_tx_clk,
  input  logic        rst_n,
  input  logic        send_req,
  input  logic [15:0] send_len,
  input  logic [7:0]  src_data,
  input  logic        src_valid,
  output logic        src_ready,
  output logic        busy,
  output logic        done,
  output logic        err_no_mac,
  output logic        arp_request_req,
  input  logic        arp_found,
  input  logic        mac_not_exist,
  output logic        udp_tx_req,
  input  logic        udp_ram_data_req,
  output logic [15:0] udp_send_data_length,
  output logic [7:0]  ram_wr_data,
  output logic        ram_wr_en,
  input  logic        almost_full,
  input  logic        udp_tx_end
);

  localparam int GAP_W = cnt_width(IFG_CYCLES);

  tx_state_t        state_reg;
  logic [15:0]      rem_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic             arp_start;
  logic             arp_resolved;
  logic             arp_failed;
  logic             wr_hs;

  assign arp_start = (state_reg == ARP_REQ);
  // An early udp_tx_end aborts the frame, so no byte is taken from the source that cycle.
  assign src_ready = (state_reg == WRITE) && (rem_reg != 16'd0) && !almost_full && !udp_tx_end;
  assign wr_hs     = src_valid && src_ready;

  udp_tx_arp_resolver #(
    .ARP_TIMEOUT (ARP_TIMEOUT),
    .ARP_RETRIES (ARP_RETRIES),
    .TMO_W       (TMO_W)
  ) u_arp (
    .gmii_tx_clk     (gmii_tx_clk),
    .rst_n           (rst_n),
    .start           (arp_start),
    .arp_found       (arp_found),
    .arp_request_req (arp_request_req),
    .resolved        (arp_resolved),
    .failed          (arp_failed)
  );

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg            <= IDLE;
      rem_reg              <= '0;
      gap_cnt_reg          <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      err_no_mac           <= 1'b0;
      udp_tx_req           <= 1'b0;
      udp_send_data_length <= '0;
      ram_wr_data          <= '0;
      ram_wr_en            <= 1'b0;
    end else begin
      done       <= 1'b0;
      err_no_mac <= 1'b0;
      ram_wr_en  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (send_req) begin
            udp_send_data_length <= send_len;
            rem_reg              <= send_len;
            if (send_len == 16'd0) begin
              done <= 1'b1;
            end else begin
              busy <= 1'b1;
              if (mac_not_exist) begin
                state_reg <= ARP_REQ;
              end else begin
                state_reg  <= TX_REQ;
                udp_tx_req <= 1'b1;
              end
            end
          end
        end
        ARP_REQ: state_reg <= ARP_WAIT;
        ARP_WAIT: begin
          if (arp_resolved) begin
            state_reg  <= TX_REQ;
            udp_tx_req <= 1'b1;
          end else if (arp_failed) begin
            err_no_mac <= 1'b1;
            busy       <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        TX_REQ: begin
          if (udp_ram_data_req) state_reg <= WRITE;
        end
        WRITE: begin
          if (udp_tx_end) begin
            udp_tx_req  <= 1'b0;
            gap_cnt_reg <= '0;
            state_reg   <= GAP;
          end else if (wr_hs) begin
            ram_wr_en   <= 1'b1;
            ram_wr_data <= src_data;
            rem_reg     <= rem_reg - 16'd1;
            if (rem_reg == 16'd1) state_reg <= WAIT_END;
          end
        end
        WAIT_END: begin
          if (udp_tx_end) begin
            done        <= 1'b1;
            udp_tx_req  <= 1'b0;
            gap_cnt_reg <= '0;
            state_reg   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt_reg == GAP_W'(IFG_CYCLES - 1)) begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_ctrl.sv
// Directed bench for udp_tx_ctrl: table of frame scenarios plus hand-written
// sequences for reset-state, busy-time requests and mid-frame reset.
module tb_udp_tx_ctrl;

  typedef struct {
    string name;
    int    len;
    bit    miss;
    int    arp_delay;
    bit    rand_valid;
    bit    af_toggle;
    bit    poke;
    int    exp_arp;
    int    exp_err;
    int    exp_done;
    int    exp_wr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        send_req;
  logic [15:0] send_len;
  logic [7:0]  src_data;
  logic        src_valid;
  logic        src_ready;
  logic        busy;
  logic        done;
  logic        err_no_mac;
  logic        arp_request_req;
  logic        arp_found;
  logic        mac_not_exist;
  logic        udp_tx_req;
  logic        udp_ram_data_req;
  logic [15:0] udp_send_data_length;
  logic [7:0]  ram_wr_data;
  logic        ram_wr_en;
  logic        almost_full;
  logic        udp_tx_end;

  int total = 0;
  int bad   = 0;

  // monitor state
  int n_arp = 0, n_err = 0, n_done = 0, n_wr = 0, n_txq = 0;
  int cyc_n = 0, last_done_cyc = 0, last_fall_cyc = 0;
  int data_bad = 0, af_bad = 0, dup_bad = 0, err_busy_bad = 0;
  int arp_times[$];
  bit hs_seen = 1'b0, hs_prev = 1'b0, busy_prev = 1'b0;

  // source / stack state driven by the main process
  int wr_base = 0;
  int src_idx = 0;
  int cyc = 0;
  bit rand_valid = 1'b0, af_toggle = 1'b0;

  vec_t tbl[7];

  udp_tx_ctrl #(
    .ARP_TIMEOUT (100),
    .ARP_RETRIES (3),
    .IFG_CYCLES  (12),
    .TMO_W       (27)
  ) dut (
    .gmii_tx_clk          (clk),
    .rst_n                (rst_n),
    .send_req             (send_req),
    .send_len             (send_len),
    .src_data             (src_data),
    .src_valid            (src_valid),
    .src_ready            (src_ready),
    .busy                 (busy),
    .done                 (done),
    .err_no_mac           (err_no_mac),
    .arp_request_req      (arp_request_req),
    .arp_found            (arp_found),
    .mac_not_exist        (mac_not_exist),
    .udp_tx_req           (udp_tx_req),
    .udp_ram_data_req     (udp_ram_data_req),
    .udp_send_data_length (udp_send_data_length),
    .ram_wr_data          (ram_wr_data),
    .ram_wr_en            (ram_wr_en),
    .almost_full          (almost_full),
    .udp_tx_end           (udp_tx_end)
  );

  initial forever #5 clk = ~clk;

  // Observer at the falling edge: counts pulses, checks write data against the source order.
  initial forever begin
    @(negedge clk);
    cyc_n++;
    if (arp_request_req) begin n_arp++; arp_times.push_back(cyc_n); end
    if (err_no_mac) begin n_err++; if (busy) err_busy_bad++; end
    if (done) begin n_done++; last_done_cyc = cyc_n; end
    if (udp_tx_req) n_txq++;
    if (busy_prev && !busy) last_fall_cyc = cyc_n;
    busy_prev = busy;
    if (ram_wr_en) begin
      if (ram_wr_data !== 8'(n_wr - wr_base + 1)) data_bad++;
      if (!hs_prev) dup_bad++;
      n_wr++;
    end
    hs_seen = src_valid && src_ready;
    if (hs_seen && almost_full) af_bad++;
    hs_prev = hs_seen;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input int len, input bit miss, input int arp_delay,
                              input bit rv, input bit af, input bit poke, input int e_arp,
                              input int e_err, input int e_done, input int e_wr);
    vec_t v;
    v.name = name; v.len = len; v.miss = miss; v.arp_delay = arp_delay;
    v.rand_valid = rv; v.af_toggle = af; v.poke = poke;
    v.exp_arp = e_arp; v.exp_err = e_err; v.exp_done = e_done; v.exp_wr = e_wr;
    return v;
  endfunction

  // One clock: advance the source on the handshake seen last falling edge, refresh stimulus.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (hs_seen) src_idx++;
    src_data         = 8'(src_idx + 1);
    src_valid        = rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
    almost_full      = af_toggle ? (((cyc / 7) % 2) == 1) : 1'b0;
    udp_ram_data_req = udp_tx_req;
  endtask

  task automatic run_frame(input vec_t v);
    int b_arp, b_err, b_done, b_txq, b_t;
    b_arp = n_arp; b_err = n_err; b_done = n_done; b_txq = n_txq; b_t = arp_times.size();
    wr_base    = n_wr;
    src_idx    = 0;
    rand_valid = v.rand_valid;
    af_toggle  = v.af_toggle;
    send_len      = 16'(v.len);
    mac_not_exist = v.miss;
    send_req      = 1'b1;
    tick();
    send_req = 1'b0;
    if (v.poke) begin
      tick();
      send_req = 1'b1;
      send_len = 16'd9;
      tick();
      send_req = 1'b0;
      check({v.name, " len held"}, int'(udp_send_data_length), v.len);
    end
    if (v.miss && v.arp_delay >= 0) begin
      for (int i = 0; i < 50 && n_arp == b_arp; i++) tick();
      check({v.name, " arp seen"}, int'(n_arp > b_arp), 1);
      repeat (v.arp_delay - 1) tick();
      arp_found = 1'b1;
      tick();
      arp_found = 1'b0;
    end
    if (v.exp_wr > 0) begin
      for (int i = 0; i < 5000 && (n_wr - wr_base) < v.len; i++) tick();
      check({v.name, " writes in time"}, int'((n_wr - wr_base) >= v.len), 1);
      repeat (3) tick();
      udp_tx_end = 1'b1;
      tick();
      udp_tx_end = 1'b0;
    end
    for (int i = 0; i < 2000 && busy; i++) tick();
    check({v.name, " busy released"}, int'(busy), 0);
    repeat (3) tick();
    check({v.name, " arp reqs"}, n_arp - b_arp, v.exp_arp);
    check({v.name, " err"}, n_err - b_err, v.exp_err);
    check({v.name, " done"}, n_done - b_done, v.exp_done);
    check({v.name, " writes"}, n_wr - wr_base, v.exp_wr);
    check({v.name, " tx_req"}, int'(n_txq > b_txq), int'(v.exp_wr > 0));
    if (v.exp_wr > 0) check({v.name, " ifg"}, last_fall_cyc - last_done_cyc, 12);
    if (v.exp_arp >= 2 && arp_times.size() >= b_t + v.exp_arp) begin
      for (int i = 1; i < v.exp_arp; i++)
        check({v.name, " arp spacing"}, arp_times[b_t + i] - arp_times[b_t + i - 1], 100);
    end
  endtask

  initial begin
    int b_done, b_err;
    rst_n = 1'b0; send_req = 1'b0; send_len = '0; src_data = '0; src_valid = 1'b0;
    arp_found = 1'b0; mac_not_exist = 1'b0; udp_ram_data_req = 1'b0;
    almost_full = 1'b0; udp_tx_end = 1'b0;

    tbl[0] = mk("hit5",    5,   1'b0, -1, 1'b0, 1'b0, 1'b0, 0, 0, 1, 5);
    tbl[1] = mk("miss64",  64,  1'b1, 40, 1'b0, 1'b0, 1'b0, 1, 0, 1, 64);
    tbl[2] = mk("arpfail", 8,   1'b1, -1, 1'b0, 1'b0, 1'b0, 3, 1, 0, 0);
    tbl[3] = mk("bp300",   300, 1'b0, -1, 1'b1, 1'b1, 1'b0, 0, 0, 1, 300);
    tbl[4] = mk("zero",    0,   1'b0, -1, 1'b0, 1'b0, 1'b0, 0, 0, 1, 0);
    tbl[5] = mk("busyreq", 4,   1'b0, -1, 1'b1, 1'b0, 1'b1, 0, 0, 1, 4);
    tbl[6] = mk("one",     1,   1'b1, 5,  1'b0, 1'b1, 1'b0, 1, 0, 1, 1);

    repeat (3) tick();
    check("reset flags", int'({busy, done, err_no_mac, arp_request_req, udp_tx_req, ram_wr_en, src_ready}), 0);
    check("reset length", int'(udp_send_data_length), 0);
    check("reset data", int'(ram_wr_data), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int k = 0; k < 7; k++) run_frame(tbl[k]);

    // Mid-frame reset after 100 of 200 bytes: everything clears at once, nothing retired.
    b_done = n_done; b_err = n_err;
    wr_base = n_wr; src_idx = 0; rand_valid = 1'b0; af_toggle = 1'b0;
    send_len = 16'd200; mac_not_exist = 1'b0; send_req = 1'b1;
    tick();
    send_req = 1'b0;
    for (int i = 0; i < 500 && (n_wr - wr_base) < 100; i++) tick();
    check("rst mid writes reached", int'((n_wr - wr_base) >= 100), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst async flags", int'({busy, done, err_no_mac, arp_request_req, udp_tx_req, ram_wr_en, src_ready}), 0);
    check("rst async length", int'(udp_send_data_length), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("rst no done", n_done - b_done, 0);
    check("rst no err", n_err - b_err, 0);
    run_frame(mk("postrst", 3, 1'b0, -1, 1'b0, 1'b0, 1'b0, 0, 0, 1, 3));

    check("write data order", data_bad, 0);
    check("write while almost_full", af_bad, 0);
    check("write without handshake", dup_bad, 0);
    check("err with busy", err_busy_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
